// File: rtl/bpu_table_ctrl.sv
// Branch-prediction table controller: arbitrates the single table port between
// IFU lookups and queued EXU read-modify-write updates, and sweeps the table clean.
module bpu_table_ctrl #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned TAG_W = 32 - IDX_W - 1,
  localparam int unsigned ENT_W = 1 + TAG_W + 32 + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             ifu2bpc_lkp_req_i,
  input  logic [31:0]      ifu2bpc_lkp_pc_i,
  output logic             bpc2ifu_lkp_gnt_o,
  output logic             bpc2ifu_lkp_vld_o,
  output logic             bpc2ifu_pred_taken_o,
  output logic [31:0]      bpc2ifu_pred_pc_o,
  input  logic             exu2bpc_upd_vld_i,
  input  logic [31:0]      exu2bpc_upd_pc_i,
  input  logic [31:0]      exu2bpc_upd_target_i,
  input  logic             exu2bpc_upd_taken_i,
  output logic             bpc2exu_upd_rdy_o,
  output logic             bpc2tbl_en_o,
  output logic             bpc2tbl_we_o,
  output logic [IDX_W-1:0] bpc2tbl_addr_o,
  output logic [ENT_W-1:0] bpc2tbl_wdata_o,
  input  logic [ENT_W-1:0] tbl2bpc_rdata_i,
  output logic             bpc2ifu_init_done_o
);

  localparam int unsigned QP_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic             init_done;
  logic             lkp_vld;
  logic [TAG_W-1:0] lkp_tag;

  // Queue entries keep pc[31:1]; bit 0 never contributes to index or tag.
  logic [30:0]      q_pc     [QDEPTH];
  logic [31:0]      q_target [QDEPTH];
  logic             q_taken  [QDEPTH];
  logic [QP_W:0]    wp, rp;
  logic             empty, full, push, pop;
  logic [30:0]      head_pc;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic [ENT_W-1:0] upd_wdata;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  logic [1:0]       rd_ctr;
  logic             upd_hit, rmw_write;
  logic [1:0]       rmw_ctr;
  logic [31:0]      rmw_target;
  logic [ENT_W-1:0] rmw_entry;

  logic             unused_pc_lsb;
  assign unused_pc_lsb = ifu2bpc_lkp_pc_i[0] ^ exu2bpc_upd_pc_i[0];

  assign rd_valid  = tbl2bpc_rdata_i[ENT_W-1];
  assign rd_tag    = tbl2bpc_rdata_i[ENT_W-2 -: TAG_W];
  assign rd_target = tbl2bpc_rdata_i[33:2];
  assign rd_ctr    = tbl2bpc_rdata_i[1:0];

  assign empty   = (wp == rp);
  assign full    = (wp[QP_W] != rp[QP_W]) && (wp[QP_W-1:0] == rp[QP_W-1:0]);
  assign head_pc = q_pc[rp[QP_W-1:0]];

  assign bpc2exu_upd_rdy_o    = !rst && !full && (state != INIT);
  assign push                 = exu2bpc_upd_vld_i && bpc2exu_upd_rdy_o;
  assign bpc2ifu_lkp_vld_o    = lkp_vld;
  assign bpc2ifu_init_done_o  = init_done;
  assign bpc2ifu_pred_taken_o = lkp_vld && rd_valid && (rd_tag == lkp_tag) && rd_ctr[1];
  assign bpc2ifu_pred_pc_o    = (lkp_vld && rd_valid && (rd_tag == lkp_tag)) ? rd_target : '0;

  always_comb begin
    upd_hit    = rd_valid && (rd_tag == upd_tag);
    rmw_write  = 1'b1;
    rmw_ctr    = 2'b10;
    rmw_target = upd_target;
    if (upd_hit) begin
      if (upd_taken) rmw_ctr = (rd_ctr == 2'b11) ? 2'b11 : rd_ctr + 2'b01;
      else           rmw_ctr = (rd_ctr == 2'b00) ? 2'b00 : rd_ctr - 2'b01;
      rmw_target = upd_taken ? upd_target : rd_target;
    end else if (!upd_taken) begin
      rmw_write = 1'b0;
    end
    rmw_entry = {1'b1, upd_tag, rmw_target, rmw_ctr};
  end

  always_comb begin
    state_nxt         = state;
    pop               = 1'b0;
    bpc2ifu_lkp_gnt_o = 1'b0;
    bpc2tbl_en_o      = 1'b0;
    bpc2tbl_we_o      = 1'b0;
    bpc2tbl_addr_o    = '0;
    bpc2tbl_wdata_o   = '0;
    case (state)
      INIT: begin
        bpc2tbl_en_o   = 1'b1;
        bpc2tbl_we_o   = 1'b1;
        bpc2tbl_addr_o = sweep_cnt;
        if (sweep_cnt == IDX_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (full || (!ifu2bpc_lkp_req_i && !empty)) begin
          pop            = 1'b1;
          bpc2tbl_en_o   = 1'b1;
          bpc2tbl_addr_o = head_pc[IDX_W-1:0];
          state_nxt      = UPD_RD;
        end else if (ifu2bpc_lkp_req_i) begin
          bpc2ifu_lkp_gnt_o = 1'b1;
          bpc2tbl_en_o      = 1'b1;
          bpc2tbl_addr_o    = ifu2bpc_lkp_pc_i[IDX_W:1];
        end
      end
      UPD_RD: state_nxt = rmw_write ? UPD_WR : IDLE;
      UPD_WR: begin
        bpc2tbl_en_o    = 1'b1;
        bpc2tbl_we_o    = 1'b1;
        bpc2tbl_addr_o  = upd_idx;
        bpc2tbl_wdata_o = upd_wdata;
        state_nxt       = IDLE;
      end
      default: state_nxt = INIT;
    endcase
    if (flush_i) state_nxt = INIT;
    if (rst) begin
      pop               = 1'b0;
      bpc2ifu_lkp_gnt_o = 1'b0;
      bpc2tbl_en_o      = 1'b0;
      bpc2tbl_we_o      = 1'b0;
      bpc2tbl_addr_o    = '0;
      bpc2tbl_wdata_o   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      init_done  <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      lkp_vld    <= 1'b0;
      lkp_tag    <= '0;
      upd_idx    <= '0;
      upd_tag    <= '0;
      upd_target <= '0;
      upd_taken  <= 1'b0;
      upd_wdata  <= '0;
    end else if (flush_i) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      lkp_vld   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lkp_vld <= bpc2ifu_lkp_gnt_o;
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (state_nxt == IDLE) init_done <= 1'b1;
      end
      if (bpc2ifu_lkp_gnt_o) lkp_tag <= ifu2bpc_lkp_pc_i[31:IDX_W+1];
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp         <= rp + 1'b1;
        upd_idx    <= head_pc[IDX_W-1:0];
        upd_tag    <= head_pc[30:IDX_W];
        upd_target <= q_target[rp[QP_W-1:0]];
        upd_taken  <= q_taken[rp[QP_W-1:0]];
      end
      if (state == UPD_RD) upd_wdata <= rmw_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wp[QP_W-1:0]]     <= exu2bpc_upd_pc_i[31:1];
      q_target[wp[QP_W-1:0]] <= exu2bpc_upd_target_i;
      q_taken[wp[QP_W-1:0]]  <= exu2bpc_upd_taken_i;
    end
  end

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Bench for bpu_table_ctrl: directed scenarios plus random traffic, scored against
// an entry-level table model with a FIFO of pending branch updates.
module tb_bpu_table_ctrl;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TAG_W = 27;
  localparam int unsigned ENT_W = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic ifu2bpc_lkp_req_i = 1'b0;
  logic [31:0] ifu2bpc_lkp_pc_i = '0;
  logic bpc2ifu_lkp_gnt_o, bpc2ifu_lkp_vld_o, bpc2ifu_pred_taken_o;
  logic [31:0] bpc2ifu_pred_pc_o;
  logic exu2bpc_upd_vld_i = 1'b0;
  logic [31:0] exu2bpc_upd_pc_i = '0;
  logic [31:0] exu2bpc_upd_target_i = '0;
  logic exu2bpc_upd_taken_i = 1'b0;
  logic bpc2exu_upd_rdy_o, bpc2tbl_en_o, bpc2tbl_we_o;
  logic [IDX_W-1:0] bpc2tbl_addr_o;
  logic [ENT_W-1:0] bpc2tbl_wdata_o;
  logic [ENT_W-1:0] tbl2bpc_rdata_i = '0;
  logic bpc2ifu_init_done_o;

  bpu_table_ctrl #(.DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ifu2bpc_lkp_req_i(ifu2bpc_lkp_req_i), .ifu2bpc_lkp_pc_i(ifu2bpc_lkp_pc_i),
    .bpc2ifu_lkp_gnt_o(bpc2ifu_lkp_gnt_o), .bpc2ifu_lkp_vld_o(bpc2ifu_lkp_vld_o),
    .bpc2ifu_pred_taken_o(bpc2ifu_pred_taken_o), .bpc2ifu_pred_pc_o(bpc2ifu_pred_pc_o),
    .exu2bpc_upd_vld_i(exu2bpc_upd_vld_i), .exu2bpc_upd_pc_i(exu2bpc_upd_pc_i),
    .exu2bpc_upd_target_i(exu2bpc_upd_target_i), .exu2bpc_upd_taken_i(exu2bpc_upd_taken_i),
    .bpc2exu_upd_rdy_o(bpc2exu_upd_rdy_o), .bpc2tbl_en_o(bpc2tbl_en_o),
    .bpc2tbl_we_o(bpc2tbl_we_o), .bpc2tbl_addr_o(bpc2tbl_addr_o),
    .bpc2tbl_wdata_o(bpc2tbl_wdata_o), .tbl2bpc_rdata_i(tbl2bpc_rdata_i),
    .bpc2ifu_init_done_o(bpc2ifu_init_done_o)
  );

  always #5 clk = ~clk;

  // Single-ported table SRAM with one-cycle read latency.
  logic [ENT_W-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '1;
  always @(posedge clk) begin
    if (bpc2tbl_en_o) begin
      if (bpc2tbl_we_o) mem[bpc2tbl_addr_o] <= bpc2tbl_wdata_o;
      else              tbl2bpc_rdata_i <= mem[bpc2tbl_addr_o];
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          tkn;
  } upd_t;

  upd_t        mq[$];
  bit          ref_v   [DEPTH];
  logic [26:0] ref_tag [DEPTH];
  logic [31:0] ref_tgt [DEPTH];
  int          ref_ctr [DEPTH];
  int          checks = 0;
  int          errors = 0;
  bit          pend = 0;
  bit          exp_taken;
  logic [31:0] exp_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 2) % DEPTH);
  endfunction

  function automatic logic [26:0] tag_of(input logic [31:0] pc);
    return 27'(pc / (2 * DEPTH));
  endfunction

  // Retire updates in order; ones that leave the table untouched are skipped.
  task automatic apply_next(output bit found, output int idx, output logic [61:0] ent);
    upd_t u;
    int i;
    found = 0;
    idx = 0;
    ent = '0;
    while (mq.size() > 0 && !found) begin
      u = mq.pop_front();
      i = idx_of(u.pc);
      if (ref_v[i] && ref_tag[i] == tag_of(u.pc)) begin
        if (u.tkn) begin
          ref_ctr[i] = (ref_ctr[i] == 3) ? 3 : ref_ctr[i] + 1;
          ref_tgt[i] = u.tgt;
        end else begin
          ref_ctr[i] = (ref_ctr[i] == 0) ? 0 : ref_ctr[i] - 1;
        end
        found = 1;
      end else if (u.tkn) begin
        ref_v[i] = 1;
        ref_tag[i] = tag_of(u.pc);
        ref_tgt[i] = u.tgt;
        ref_ctr[i] = 2;
        found = 1;
      end
      if (found) begin
        idx = i;
        ent = {1'b1, ref_tag[i], ref_tgt[i], 2'(ref_ctr[i])};
      end
    end
  endtask

  task automatic monitor();
    bit found;
    int idx;
    logic [61:0] ent;
    if (rst) return;
    check("lkp_vld", bpc2ifu_lkp_vld_o, pend);
    if (pend && bpc2ifu_lkp_vld_o) begin
      check("pred_taken", bpc2ifu_pred_taken_o, exp_taken);
      check("pred_pc", bpc2ifu_pred_pc_o, exp_pc);
    end
    pend = 0;
    if (bpc2tbl_en_o && bpc2tbl_we_o && bpc2ifu_init_done_o) begin
      apply_next(found, idx, ent);
      check("upd_write_expected", found, 1'b1);
      if (found) begin
        check("upd_addr", bpc2tbl_addr_o, idx);
        check("upd_wdata", bpc2tbl_wdata_o, ent);
      end
    end
    if (bpc2ifu_lkp_gnt_o) begin
      idx = idx_of(ifu2bpc_lkp_pc_i);
      check("lkp_rd", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b0, 4'(idx)});
      if (!flush_i) begin
        pend = 1;
        exp_taken = ref_v[idx] && ref_tag[idx] == tag_of(ifu2bpc_lkp_pc_i) && ref_ctr[idx] >= 2;
        exp_pc = (ref_v[idx] && ref_tag[idx] == tag_of(ifu2bpc_lkp_pc_i)) ? ref_tgt[idx] : '0;
      end
    end
    if (exu2bpc_upd_vld_i && bpc2exu_upd_rdy_o && !flush_i)
      mq.push_back('{pc: exu2bpc_upd_pc_i, tgt: exu2bpc_upd_target_i, tkn: exu2bpc_upd_taken_i});
    if (flush_i) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) ref_v[i] = 0;
      pend = 0;
    end
  endtask

  task automatic smp();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tkn);
    exu2bpc_upd_vld_i = 1'b1;
    exu2bpc_upd_pc_i = pc;
    exu2bpc_upd_target_i = tgt;
    exu2bpc_upd_taken_i = tkn;
  endtask

  task automatic idle_cycles(input int n);
    ifu2bpc_lkp_req_i = 1'b0;
    exu2bpc_upd_vld_i = 1'b0;
    repeat (n) begin smp(); adv(); end
  endtask

  // Expects the first sweep cycle to be the next one; returns at the sample of cycle 17.
  task automatic sweep_check(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      smp();
      check({name, "_wr"}, {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b1, 4'(i)});
      check({name, "_wdata"}, bpc2tbl_wdata_o, '0);
      check({name, "_gnt_rdy_done"}, {bpc2ifu_lkp_gnt_o, bpc2exu_upd_rdy_o, bpc2ifu_init_done_o}, 3'b000);
      adv();
    end
    smp();
    check({name, "_init_done"}, bpc2ifu_init_done_o, 1'b1);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] t, i;
    t = $urandom_range(8, 10);
    i = $urandom_range(0, DEPTH - 1);
    return (t * 32) + (i * 2);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_v[i] = 0; ref_tag[i] = '0; ref_tgt[i] = '0; ref_ctr[i] = 0;
    end
    // Reset: everything quiet even with a lookup pending.
    ifu2bpc_lkp_req_i = 1'b1;
    ifu2bpc_lkp_pc_i = 32'h104;
    smp();
    check("rst_tbl", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o, bpc2tbl_wdata_o}, '0);
    check("rst_ctl", {bpc2ifu_lkp_gnt_o, bpc2exu_upd_rdy_o, bpc2ifu_init_done_o, bpc2ifu_lkp_vld_o}, 4'b0000);
    adv();
    smp(); adv();
    rst = 1'b0;

    sweep_check("sweep");
    check("first_gnt", bpc2ifu_lkp_gnt_o, 1'b1);
    adv();

    // Allocate 0x104 -> 0x200.
    ifu2bpc_lkp_req_i = 1'b0;
    set_upd(32'h104, 32'h200, 1'b1);
    smp();
    check("alloc_push_rdy", bpc2exu_upd_rdy_o, 1'b1);
    adv();
    exu2bpc_upd_vld_i = 1'b0;
    smp();
    check("alloc_rd", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b0, 4'd2});
    adv();
    smp();
    check("alloc_updrd_en", bpc2tbl_en_o, 1'b0);
    adv();
    smp();
    check("alloc_wr", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b1, 4'd2});
    check("alloc_wdata", bpc2tbl_wdata_o, {1'b1, 27'd8, 32'h200, 2'b10});
    adv();
    ifu2bpc_lkp_req_i = 1'b1;
    ifu2bpc_lkp_pc_i = 32'h104;
    smp();
    check("lkp104_gnt", bpc2ifu_lkp_gnt_o, 1'b1);
    adv();
    ifu2bpc_lkp_req_i = 1'b0;
    smp();
    check("lkp104_res", {bpc2ifu_lkp_vld_o, bpc2ifu_pred_taken_o, bpc2ifu_pred_pc_o}, {1'b1, 1'b1, 32'h200});
    adv();

    // Three not-taken updates walk the counter down and saturate.
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h104, 32'h999, 1'b0);
      smp(); adv();
    end
    idle_cycles(12);
    ifu2bpc_lkp_req_i = 1'b1;
    ifu2bpc_lkp_pc_i = 32'h104;
    smp(); adv();
    ifu2bpc_lkp_req_i = 1'b0;
    smp();
    check("dec_res", {bpc2ifu_lkp_vld_o, bpc2ifu_pred_taken_o, bpc2ifu_pred_pc_o}, {1'b1, 1'b0, 32'h200});
    adv();

    // Miss + not taken: read, then no write slot.
    set_upd(32'h300, 32'h444, 1'b0);
    smp(); adv();
    exu2bpc_upd_vld_i = 1'b0;
    smp();
    check("miss_nt_rd", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b0, 4'd0});
    adv();
    smp(); adv();
    smp();
    check("miss_nt_nowr", bpc2tbl_en_o, 1'b0);
    adv();

    // Lookups held high: queue fills, then full forces an update slot.
    ifu2bpc_lkp_req_i = 1'b1;
    ifu2bpc_lkp_pc_i = 32'h104;
    for (int k = 0; k < 4; k++) begin
      set_upd(32'h10 * (k + 1), 32'h1000 + k, 1'b1);
      smp();
      check("fill_rdy_gnt", {bpc2exu_upd_rdy_o, bpc2ifu_lkp_gnt_o}, 2'b11);
      adv();
    end
    exu2bpc_upd_vld_i = 1'b0;
    smp();
    check("full_rdy_gnt", {bpc2exu_upd_rdy_o, bpc2ifu_lkp_gnt_o}, 2'b00);
    check("full_pop_rd", {bpc2tbl_en_o, bpc2tbl_we_o, bpc2tbl_addr_o}, {1'b1, 1'b0, 4'd8});
    adv();
    smp();
    check("after_pop_rdy", {bpc2exu_upd_rdy_o, bpc2ifu_lkp_gnt_o}, 2'b10);
    adv();
    idle_cycles(12);

    // Flush in UPD_RD with two updates still queued.
    ifu2bpc_lkp_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h50 + 32'h10 * k, 32'h2000 + k, 1'b1);
      smp(); adv();
    end
    ifu2bpc_lkp_req_i = 1'b0;
    exu2bpc_upd_vld_i = 1'b0;
    smp(); adv();
    flush_i = 1'b1;
    smp();
    check("flush_updrd_en", bpc2tbl_en_o, 1'b0);
    adv();
    flush_i = 1'b0;
    sweep_check("resweep");
    check("resweep_empty", {bpc2tbl_en_o, bpc2exu_upd_rdy_o}, 2'b01);
    adv();
    smp();
    check("resweep_idle", bpc2tbl_en_o, 1'b0);
    adv();

    // Same index, different tag.
    set_upd(32'h104, 32'h200, 1'b1);
    smp(); adv();
    idle_cycles(5);
    ifu2bpc_lkp_req_i = 1'b1;
    ifu2bpc_lkp_pc_i = 32'h144;
    smp(); adv();
    ifu2bpc_lkp_req_i = 1'b0;
    smp();
    check("alias_res", {bpc2ifu_lkp_vld_o, bpc2ifu_pred_taken_o, bpc2ifu_pred_pc_o}, {1'b1, 1'b0, 32'h0});
    adv();

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      ifu2bpc_lkp_req_i = ($urandom_range(0, 1) == 1);
      ifu2bpc_lkp_pc_i = rnd_pc();
      exu2bpc_upd_vld_i = ($urandom_range(0, 9) < 4);
      exu2bpc_upd_pc_i = rnd_pc();
      exu2bpc_upd_target_i = $urandom;
      exu2bpc_upd_taken_i = ($urandom_range(0, 1) == 1);
      flush_i = ($urandom_range(0, 199) == 0);
      smp(); adv();
    end
    flush_i = 1'b0;
    idle_cycles(40);
    begin
      bit found;
      int idx;
      logic [61:0] ent;
      apply_next(found, idx, ent);
      check("drain_no_pending_write", found, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
